// File: rtl/sbox_layer_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_layer_serial_pkg
//  Purpose  : Shared definitions for the serial SWAN S-box layer: nibble
//             size, FSM state encoding and a constant-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package sbox_layer_serial_pkg;

    // Width of one S-box input/output in bits.
    localparam int c_sbox_size = 4;

    // Layer controller states. The encodings are fixed because other SWAN
    // blocks decode the same values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int steps);
        return (clog2(steps) < 1) ? 1 : clog2(steps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_layer_serial_sbox.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_layer_serial_sbox
//  Purpose  : The 4-bit SWAN S-box, purely combinational.
//  Ports    : i_nib  [3:0]  nibble in  (bit 3 = MSB)
//             o_nib  [3:0]  substituted nibble out
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_layer_serial_sbox (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = 4'h0;
        case (i_nib)
            4'h0: o_nib = 4'h1;
            4'h1: o_nib = 4'h2;
            4'h2: o_nib = 4'hC;
            4'h3: o_nib = 4'h5;
            4'h4: o_nib = 4'h7;
            4'h5: o_nib = 4'h8;
            4'h6: o_nib = 4'hA;
            4'h7: o_nib = 4'hF;
            4'h8: o_nib = 4'h4;
            4'h9: o_nib = 4'hD;
            4'hA: o_nib = 4'hB;
            4'hB: o_nib = 4'hE;
            4'hC: o_nib = 4'h9;
            4'hD: o_nib = 4'h6;
            4'hE: o_nib = 4'h0;
            4'hF: o_nib = 4'h3;
            default: o_nib = 4'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sbox_layer_serial.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_layer_serial
//  Purpose  : Applies the SWAN S-box to every nibble of a WIDTH-bit word by
//             time-sharing LANES S-box instances over STEPS cycles.
//  Ports    : clk, rst             clock, synchronous active-high reset
//             in_valid/in_ready    input handshake, in_data [0:WIDTH-1]
//             out_valid/out_ready  output handshake, out_data [0:WIDTH-1]
//             busy                 high while a word is being processed/held
//             Nibble i occupies bits [4i:4i+3], bit 4i being its MSB.
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_layer_serial
    import sbox_layer_serial_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_data,
    output logic             busy
);

    localparam int c_nib   = WIDTH / c_sbox_size;
    localparam int c_steps = c_nib / LANES;
    localparam int c_cw    = cnt_width(c_steps);
    localparam int c_lw    = c_sbox_size * LANES;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_steps - 1);

    state_t           r_state;
    logic [c_cw-1:0]  r_cnt;
    logic [0:WIDTH-1] r_data;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [0:c_lw-1]  w_lane_out;
    logic [0:WIDTH-1] w_next;

    // Lane j always works on the leading nibble slot j; the rotation brings
    // a fresh group of nibbles into those slots every cycle.
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            sbox_layer_serial_sbox u_sbox (
                .i_nib (r_data[c_sbox_size*j +: c_sbox_size]),
                .o_nib (w_lane_out[c_sbox_size*j +: c_sbox_size])
            );
        end
    endgenerate

    // Left rotate by one lane group, substituting the group that wraps round.
    // With one step the whole word is substituted at once and nothing rotates.
    generate
        if (c_steps == 1) begin : g_full
            assign w_next = w_lane_out;
        end else begin : g_rot
            assign w_next = {r_data[c_lw:WIDTH-1], w_lane_out};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_data      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data     <= in_data;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_data <= w_next;
                    if (r_cnt == c_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Input stays closed here even when the result is being
                    // taken, so one word is in flight at a time.
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign busy      = r_busy;

endmodule
`default_nettype wire
